// File: rtl/rom_burst_reader.sv
// Banked read-only lookup table (word[a] = 3a+1) with a flow-controlled burst read port.
// Words are returned one per cycle from a registered output stage; addresses wrap at the end of the table.
module rom_burst_reader #(
    parameter int DATA_W     = 8,
    parameter int BANK_DEPTH = 8,
    parameter int NUM_BANKS  = 3,
    parameter int ADDR_W     = 5,
    parameter int LEN_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] bank_idx,
    output logic              busy,
    output logic              err
);

    localparam int TOTAL = NUM_BANKS * BANK_DEPTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(BANK_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    function automatic logic [DATA_W-1:0] rom_word(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd3 * a + 32'd1;
        return v[DATA_W-1:0];
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic [ADDR_W-1:0] bank_q, bank_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              active;
    logic              advance;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_off;
    logic [DATA_W-1:0] rd_word;

    assign in_range = 32'(addr) < 32'(TOTAL);
    assign active   = (state_q != S_IDLE);
    // cur_q tracks the word currently on data_out; on a non-final consume the next word is fetched
    assign advance  = active && cs && dv_q && ready && (rem_q != '0);
    assign nxt_addr = (cur_q == LAST_ADDR) ? '0 : cur_q + ADDR_W'(1);
    assign rd_addr  = advance ? nxt_addr : cur_q;
    assign rd_bank  = rd_addr / DEPTH_A;
    assign rd_off   = rd_addr % DEPTH_A;

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank == ADDR_W'(b)) begin
                rd_word = rom_word(32'(b * BANK_DEPTH) + 32'(rd_off));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        bank_d  = bank_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                dv_d = 1'b0;
                if (cs && read_en) begin
                    if (in_range) begin
                        cur_d   = addr;
                        rem_d   = burst_len;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN, S_STALL: begin
                if (!cs) begin
                    state_d = S_IDLE;
                    dv_d    = 1'b0;
                end else if (dv_q && ready) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        dv_d    = 1'b0;
                    end else begin
                        rem_d   = rem_q - LEN_W'(1);
                        cur_d   = nxt_addr;
                        dout_d  = rd_word;
                        bank_d  = rd_bank;
                        dv_d    = 1'b1;
                        state_d = S_RUN;
                    end
                end else if (dv_q) begin
                    state_d = S_STALL;
                end else begin
                    // first beat of a burst: nothing presented yet
                    dout_d  = rd_word;
                    bank_d  = rd_bank;
                    dv_d    = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                dv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            bank_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign bank_idx   = bank_q;
    assign busy       = active;
    assign err        = err_q;

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Parametrised banked read-only memory with a burst read engine. It generalises the fixed 24x8 ROM, built from three 8x8 banks, to NUM_BANKS banks of BANK_DEPTH words of DATA_W bits each. A registered, flow-controlled read port returns one word per cycle for bursts of up to 2^LEN_W words, with address wrap-around. It sits between a bus master and the lookup-table storage, replacing direct combinational ROM reads.

## Interface
- DATA_W, 8, word width in bits
- BANK_DEPTH, 8, words per bank; power of two
- NUM_BANKS, 3, number of banks; TOTAL = NUM_BANKS*BANK_DEPTH
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= TOTAL
- LEN_W, 4, burst-length field width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cs  in  1  chip select; low aborts any activity
- read_en  in  1  request strobe, sampled only in IDLE
- addr  in  ADDR_W  start word address
- burst_len  in  LEN_W  beats minus one (0 = single read)
- ready  in  1  consumer accepts data_out this cycle
- data_out  out  DATA_W  read word
- data_valid  out  1  data_out valid
- bank_idx  out  ADDR_W  bank of the word on data_out (addr / BANK_DEPTH)
- busy  out  1  request in progress (state != IDLE)
- err  out  1  one-cycle pulse: start address out of range

## Operation
- Contents: word[a] = (3*a + 1) mod 2^DATA_W for a in 0..TOTAL-1. This is fixed at elaboration and is the test model.
- Bank select = cur_addr / BANK_DEPTH. Offset = cur_addr mod BANK_DEPTH. Only the selected bank drives data.
- FSM states: IDLE, RUN, STALL.
- IDLE:
  - If cs & read_en & addr < TOTAL: latch cur_addr=addr and remaining=burst_len, then go to RUN.
  - If cs & read_en & addr >= TOTAL: pulse err for 1 cycle, stay IDLE, data_valid stays 0.
- RUN: each cycle, register word[cur_addr] onto data_out and assert data_valid.
  - A beat is consumed when data_valid & ready.
  - On consume: if remaining==0, go to IDLE. Otherwise decrement remaining and advance cur_addr.
  - Address advance: cur_addr+1, wrapping to 0 when cur_addr==TOTAL-1.
  - If data_valid & !ready: go to STALL.
- STALL: data_out, bank_idx and data_valid are held stable. When ready rises, consume as in RUN.
- cs low in RUN or STALL: abort. Next cycle state=IDLE, data_valid=0, and unconsumed beats are discarded.
- read_en is ignored while busy. A new request is accepted at the earliest on the cycle after busy falls.
- Remaining-counter width is LEN_W. The maximum burst is 2^LEN_W beats and may wrap the address more than once.

## Timing
- Reset values: data_out=0, data_valid=0, bank_idx=0, busy=0, err=0, state=IDLE.
- Reset takes effect on the next clock edge from any state, including mid-burst and mid-stall.
- Latency: request sampled at edge N. First data_valid=1 with word[addr] appears after edge N+1. busy=1 after edge N.
- With ready held high, a burst of L+1 beats takes L+1 consecutive valid cycles. data_valid and busy drop after the edge that consumes the last beat.
- err is asserted after edge N and cleared after edge N+1.
- Back-to-back requests: minimum one IDLE cycle between bursts.

## Test plan
- Reset, then single read: addr=7, burst_len=0, ready=1. One valid beat: data_out=8'h16, bank_idx=0. busy then falls.
- Cross-bank burst: addr=6, burst_len=3, ready=1. Beats are 8'h13, 8'h16, 8'h19, 8'h1C on consecutive cycles, with bank_idx 0, 0, 1, 1.
- Wrap-around: addr=22, burst_len=3. Beats are word[22]=8'h43, word[23]=8'h46, word[0]=8'h01, word[1]=8'h04, with bank_idx 2, 2, 0, 0.
- Backpressure: addr=16, burst_len=2, ready low for 3 cycles after the first valid. data_out holds 8'h31 and bank_idx holds 2 through the stall. Then 8'h31, 8'h34, 8'h37 are delivered with no beat lost or duplicated.
- Out-of-range: addr=25. err pulses for exactly one cycle, data_valid stays 0, busy stays 0.
- Abort and reset: cs drops during the second beat of a 4-beat burst from addr=8, so data_valid=0 next cycle. Separately, rst during STALL clears all outputs next cycle. A following read of addr=15 returns 8'h2E.
